// File: rtl/button_pkg.sv
// Shared definitions for the button shaper: per-channel FSM encoding,
// a constant clog2-style width helper, and the inactive-level helper.
package button_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRESS_DB = 3'd1,
        ST_PULSE    = 3'd2,
        ST_HELD     = 3'd3,
        ST_REL_DB   = 3'd4
    } btn_state_e;

    // Bits needed to hold values 0..value-1 (minimum 1).
    function automatic int clog2_width(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    // Raw level of a released button.
    function automatic logic inactive_level(input int active_low);
        return (active_low != 0);
    endfunction

endpackage

// File: rtl/button_shaper_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM and counter.
// Auto-repeat counter is built only when AUTO_REPEAT_EN is defined.
module button_shaper_ch
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 1000,
    parameter int REPEAT_PERIOD   = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic b_raw,
    output logic b_pulse,
    output logic b_held
);
    localparam int            CW       = clog2_width(DEBOUNCE_CYCLES + 1);
    localparam logic          IDLE_LVL = inactive_level(ACTIVE_LOW);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

    logic          sync_q1, sync_q2, act;
    btn_state_e    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic          rep_hit, pulse_nxt, held_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q1 <= IDLE_LVL;
            sync_q2 <= IDLE_LVL;
        end else begin
            sync_q1 <= b_raw;
            sync_q2 <= sync_q1;
        end
    end

    assign act     = (sync_q2 != IDLE_LVL);
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: if (act) begin
                state_nxt = ST_PRESS_DB;
                cnt_nxt   = CW'(1);
            end
            ST_PRESS_DB: if (!act) begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end else if (cnt_inc == CNT_MAX) begin
                state_nxt = ST_PULSE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt   = cnt_inc;
            end
            ST_PULSE: state_nxt = ST_HELD;
            ST_HELD: if (!act) begin
                state_nxt = ST_REL_DB;
                cnt_nxt   = CW'(1);
            end
            ST_REL_DB: if (act) begin
                state_nxt = ST_HELD;
                cnt_nxt   = '0;
            end else if (cnt_inc == CNT_MAX) begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt   = cnt_inc;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        pulse_nxt = (state == ST_PULSE) || rep_hit;
        held_nxt  = (state == ST_HELD) || (state == ST_REL_DB);
    end

    // Registered outputs add the final cycle of edge-to-pulse latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_pulse <= 1'b0;
            b_held  <= 1'b0;
        end else begin
            b_pulse <= pulse_nxt;
            b_held  <= held_nxt;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = clog2_width(RMAX + 1);

    logic [RW-1:0] rep_cnt, rep_target;
    logic          rep_phase;

    // First hit waits REPEAT_DELAY, later hits REPEAT_PERIOD.
    assign rep_target = rep_phase ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY);
    assign rep_hit    = (state == ST_HELD) && (rep_cnt == rep_target);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end else if (state == ST_HELD) begin
            if (rep_hit) begin
                rep_cnt   <= RW'(1);
                rep_phase <= 1'b1;
            end else begin
                rep_cnt   <= rep_cnt + 1'b1;
            end
        end else if (state != ST_REL_DB) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end
    end
`else
    logic unused_repeat;
    assign rep_hit       = 1'b0;
    assign unused_repeat = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

endmodule

// File: rtl/multi_button_shaper.sv
// N_CH independent debounced button channels with press pulse and held level.
// Optional auto-repeat pulses are enabled by defining AUTO_REPEAT_EN.
module multi_button_shaper #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 1000,
    parameter int REPEAT_PERIOD   = 250
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] b_in,
    output logic [N_CH-1:0] b_pulse,
    output logic [N_CH-1:0] b_held
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_shaper_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .b_raw  (b_in[i]),
            .b_pulse(b_pulse[i]),
            .b_held (b_held[i])
        );
    end

endmodule

// File: tb/tb_multi_button_shaper.sv
// Self-checking bench for multi_button_shaper: directed timing scenarios plus
// randomized button activity compared against a run-length reference model.
module tb_multi_button_shaper;
    localparam int N  = 4;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 5;
`ifdef AUTO_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic         clk  = 1'b0;
    logic         rst  = 1'b0;
    logic [N-1:0] b_in = '1;
    logic [N-1:0] b_pulse, b_held;
    int checks = 0;
    int errors = 0;

    multi_button_shaper #(
        .N_CH(N), .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .b_in(b_in), .b_pulse(b_pulse), .b_held(b_held)
    );

    always #5 clk = ~clk;

    // Reference model: a press is accepted after DB consecutive active
    // synchronized samples, a release after DB consecutive inactive ones
    // (counting starts after the pulse cycle); outputs lag by one cycle.
    logic [N-1:0] m_s1 = '1, m_s2 = '1, m_pulse = '0, m_held = '0;
    int m_run[N];
    bit m_acc[N];
    bit m_fresh[N];
    int m_ht[N];

    function automatic bit rep_due(input int t);
        return (t == RD) || (t > RD && ((t - RD) % RP) == 0);
    endfunction

    initial begin : model
        bit act, holding;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_s1 = '1; m_s2 = '1; m_pulse = '0; m_held = '0;
                for (int i = 0; i < N; i++) begin
                    m_run[i] = 0; m_acc[i] = 0; m_fresh[i] = 0; m_ht[i] = 0;
                end
            end else begin
                for (int i = 0; i < N; i++) begin
                    act      = !m_s2[i];
                    m_s2[i]  = m_s1[i];
                    m_s1[i]  = b_in[i];
                    holding  = m_acc[i] && !m_fresh[i] && (m_run[i] == 0);
                    m_held[i]  = m_acc[i] && !m_fresh[i];
                    m_pulse[i] = m_fresh[i] || (REP && holding && rep_due(m_ht[i]));
                    if (holding) m_ht[i]++;
                    if (!m_acc[i]) begin
                        m_run[i] = act ? m_run[i] + 1 : 0;
                        if (m_run[i] == DB) begin
                            m_acc[i] = 1; m_fresh[i] = 1; m_run[i] = 0; m_ht[i] = 0;
                        end
                    end else if (m_fresh[i]) begin
                        m_fresh[i] = 0;
                    end else begin
                        m_run[i] = !act ? m_run[i] + 1 : 0;
                        if (m_run[i] == DB) begin
                            m_acc[i] = 0; m_run[i] = 0; m_ht[i] = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        b_in = '1;
        repeat (20) step();
    endtask

    task automatic test_reset();
        int pc;
        logic [N-1:0] pv;
        b_in = '0;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (b_pulse !== '0 || b_held !== '0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: pulse=%b held=%b, expected 0000/0000", k, b_pulse, b_held);
            end
        end
        @(posedge clk);
        #3 rst = 1'b1;
        pc = -1; pv = '0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (b_pulse !== '0 && pc < 0) begin pc = k; pv = b_pulse; end
        end
        checks++;
        if (pc != DB + 3 || pv !== 4'b1111) begin
            errors++;
            $display("FAIL held_through_reset: pulse %b at cyc %0d, expected 1111 at %0d", pv, pc, DB + 3);
        end
        settle();
    endtask

    task automatic test_clean_press();
        int pc, np, hr, hf;
        pc = -1; np = 0; hr = -1; hf = -1;
        step();
        b_in[0] = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (b_pulse[0] && k <= 15) begin np++; if (pc < 0) pc = k; end
            if (b_held[0] && hr < 0) hr = k;
            if (!b_held[0] && hr >= 0 && hf < 0) hf = k;
            if (k == 20) b_in[0] = 1'b1;
        end
        checks++;
        if (pc != 7) begin errors++; $display("FAIL clean_pulse_cyc: got %0d, expected 7", pc); end
        checks++;
        if (np != 1) begin errors++; $display("FAIL clean_pulse_width: got %0d, expected 1", np); end
        checks++;
        if (hr != 8) begin errors++; $display("FAIL clean_held_rise: got %0d, expected 8", hr); end
        checks++;
        if (hf != 27) begin errors++; $display("FAIL clean_held_fall: got %0d, expected 27", hf); end
        settle();
    endtask

    task automatic test_bounce();
        int pc, np;
        pc = -1; np = 0;
        step();
        b_in[1] = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (b_pulse[1]) begin np++; if (pc < 0) pc = k; end
            if (k >= 1 && k <= 4) b_in[1] = (k % 2 == 1);
        end
        checks++;
        if (np != 1 || pc != 11) begin
            errors++;
            $display("FAIL bounce: %0d pulses first at %0d, expected 1 at 11", np, pc);
        end
        settle();
    endtask

    task automatic test_release_glitch();
        int np_early, np_win, held_bad;
        np_early = 0; np_win = 0; held_bad = 0;
        step();
        b_in[2] = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            step();
            if (k < 9 && b_pulse[2]) np_early++;
            if (k >= 9 && b_pulse[2]) np_win++;
            if (k >= 8 && !b_held[2]) held_bad++;
            if (k == 10) b_in[2] = 1'b1;
            if (k == 12) b_in[2] = 1'b0;
        end
        checks++;
        if (np_early != 1) begin errors++; $display("FAIL glitch_first_pulse: got %0d pulses, expected 1", np_early); end
        checks++;
        if (np_win != 0) begin errors++; $display("FAIL glitch_extra_pulse: got %0d, expected 0", np_win); end
        checks++;
        if (held_bad != 0) begin errors++; $display("FAIL glitch_held_drop: %0d low cycles, expected 0", held_bad); end
        settle();
    endtask

    task automatic test_simultaneous();
        int pc, np;
        logic [N-1:0] pv, h6, h7;
        pc = -1; np = 0; pv = '0; h6 = '0; h7 = '1;
        step();
        b_in = '0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (b_pulse !== '0) begin np++; if (pc < 0) begin pc = k; pv = b_pulse; end end
        end
        b_in = '1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 6) h6 = b_held;
            if (k == 7) h7 = b_held;
        end
        checks++;
        if (pc != 7 || pv !== 4'b1111 || np != 1) begin
            errors++;
            $display("FAIL simul_pulse: %b at %0d (%0d cycles), expected 1111 at 7 (1)", pv, pc, np);
        end
        checks++;
        if (h6 !== 4'b1111 || h7 !== 4'b0000) begin
            errors++;
            $display("FAIL simul_release: held c6=%b c7=%b, expected 1111/0000", h6, h7);
        end
        settle();
    endtask

    task automatic test_reset_mid();
        int pc;
        logic [N-1:0] pv;
        step();
        b_in[3] = 1'b0;
        for (int k = 1; k <= 12; k++) step();
        b_in[0] = 1'b0;
        repeat (3) step();
        checks++;
        if (b_held !== 4'b1000) begin errors++; $display("FAIL pre_reset_held: got %b, expected 1000", b_held); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (b_held !== '0 || b_pulse !== '0) begin
            errors++;
            $display("FAIL async_reset: pulse=%b held=%b, expected 0000/0000", b_pulse, b_held);
        end
        repeat (3) step();
        #2 rst = 1'b1;
        pc = -1; pv = '0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (b_pulse !== '0 && pc < 0) begin pc = k; pv = b_pulse; end
        end
        checks++;
        if (pc != 7 || pv !== 4'b1001) begin
            errors++;
            $display("FAIL reset_repress: %b at %0d, expected 1001 at 7", pv, pc);
        end
        settle();
    endtask

    task automatic test_repeat();
        int q[$];
`ifdef AUTO_REPEAT_EN
        int expq[$] = '{7, 18, 23, 28, 33};
`else
        int expq[$] = '{7};
`endif
        step();
        b_in[3] = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            step();
            if (b_pulse[3]) q.push_back(k);
            if (k == 30) b_in[3] = 1'b1;
        end
        checks++;
        if (q.size() != expq.size()) begin
            errors++;
            $display("FAIL repeat_count: got %0d pulses, expected %0d", q.size(), expq.size());
        end else begin
            for (int i = 0; i < expq.size(); i++) begin
                checks++;
                if (q[i] != expq[i]) begin
                    errors++;
                    $display("FAIL repeat_pulse%0d: at cyc %0d, expected %0d", i, q[i], expq[i]);
                end
            end
        end
        settle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 9) == 0) b_in[i] = ~b_in[i];
            step();
            checks++;
            if (b_pulse !== m_pulse || b_held !== m_held) begin
                errors++;
                $display("FAIL random cyc %0d: pulse=%b held=%b, expected %b/%b", c, b_pulse, b_held, m_pulse, m_held);
            end
            if (c == 1500) begin
                #2 rst = 1'b0;
                #1;
                checks++;
                if (b_pulse !== '0 || b_held !== '0) begin
                    errors++;
                    $display("FAIL random_reset: pulse=%b held=%b, expected 0000/0000", b_pulse, b_held);
                end
                repeat (2) step();
                #2 rst = 1'b1;
            end
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_glitch();
        test_simultaneous();
        test_reset_mid();
        test_repeat();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_button_shaper.md
MULTI_BUTTON_SHAPER -- requirements
Module: multi_button_shaper

Interface
REQ-001 Parameter N_CH, default 4: number of independent button channels (1..16).
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized samples required to accept a press or release (2..65535).
REQ-003 Parameter ACTIVE_LOW, default 1: 1 = pressed button reads 0; 0 = pressed button reads 1.
REQ-004 Parameters REPEAT_DELAY, default 1000, and REPEAT_PERIOD, default 250: auto-repeat timing in cycles; they are used only under REQ-020.
REQ-005 Port clk, input, 1: single clock for all logic.
REQ-006 Port rst, input, 1: asynchronous, active-low reset.
REQ-007 Port b_in, input, N_CH: raw asynchronous button levels.
REQ-008 Port b_pulse, output, N_CH: per channel, a single-cycle high pulse per accepted press (and per repeat).
REQ-009 Port b_held, output, N_CH: per channel, high while the press is accepted and the release is not yet accepted.

Function
REQ-010 Each b_in bit SHALL pass through a 2-flop synchronizer; channels SHALL be fully independent.
REQ-011 The per-channel FSM SHALL have the states IDLE, PRESS_DB, PULSE, HELD and REL_DB.
REQ-012 IDLE: a synchronized active sample SHALL cause the transition to PRESS_DB with the counter set to 1.
REQ-013 PRESS_DB: on an active sample, the counter SHALL increment; at DEBOUNCE_CYCLES the FSM SHALL go to PULSE; any inactive sample SHALL return the FSM to IDLE with the counter cleared.
REQ-014 PULSE: b_pulse SHALL be 1 for exactly this one cycle, and the FSM SHALL go unconditionally to HELD.
REQ-015 HELD: b_held SHALL be 1; an inactive sample SHALL cause the transition to REL_DB with the counter set to 1.
REQ-016 REL_DB: b_held SHALL stay 1; the counter SHALL increment on inactive samples; at DEBOUNCE_CYCLES the FSM SHALL go to IDLE; any active sample SHALL return the FSM to HELD.
REQ-017 Latency from a clean raw edge to b_pulse SHALL be exactly DEBOUNCE_CYCLES+3 cycles, and b_held SHALL rise in the cycle after b_pulse.
REQ-018 The counter width SHALL be clog2(DEBOUNCE_CYCLES+1); the counter SHALL saturate and never wrap.
REQ-019 Simultaneous presses on several channels SHALL each produce their own pulse in the same cycle; there is no arbitration.

Configuration
REQ-020 With AUTO_REPEAT_EN defined, the following behaviour SHALL apply:
  - A repeat counter SHALL run in HELD.
  - An extra one-cycle b_pulse SHALL occur REPEAT_DELAY cycles after entering HELD, then every REPEAT_PERIOD cycles.
  - The repeat counter SHALL freeze in REL_DB.
  - The repeat counter SHALL resume without clearing on a return to HELD.
  - The repeat counter SHALL clear in IDLE.
REQ-021 Without AUTO_REPEAT_EN, no repeat logic SHALL be synthesized; REPEAT_DELAY and REPEAT_PERIOD SHALL be ignored, and exactly one pulse SHALL occur per press.

Reset
REQ-022 While rst=0, the following SHALL hold:
  - All FSMs SHALL be in IDLE.
  - All counters SHALL be 0.
  - b_pulse and b_held SHALL be 0.
  - The synchronizer flops SHALL hold the inactive level (1 if ACTIVE_LOW=1, else 0).
  All of this SHALL take effect immediately, without a clock.
REQ-023 A button held through reset deassertion SHALL be debounced as a new press: one pulse after DEBOUNCE_CYCLES+3 cycles.
REQ-024 Reset mid-pulse or mid-debounce SHALL abort the operation with no residual pulse.

Structure
REQ-025 Package button_pkg SHALL hold the FSM state encoding, the clog2 width function and the inactive-level helper.
REQ-026 One sub-module SHALL be used: button_shaper_ch, containing one synchronizer, FSM, debounce counter and optional repeat counter, instantiated N_CH times in a generate loop.

Verification
All scenarios use N_CH=4, DEBOUNCE_CYCLES=4 and ACTIVE_LOW=1.
REQ-027 Clean press: b_in[0] goes 1->0 and is held 20 cycles -> b_pulse[0] is high for 1 cycle at cycle 7 after the edge; b_held[0] rises at cycle 8.
REQ-028 Bounce: b_in[1] toggles 0/1/0/1 at 1-cycle spacing, then holds 0 -> no pulse during the bounce; exactly one pulse 7 cycles after the final stable edge.
REQ-029 Release glitch: in HELD, b_in[2] goes high for 2 cycles, then low -> b_held[2] stays 1 and no second pulse occurs.
REQ-030 Simultaneous presses: b_in=4'b0000 at one edge -> b_pulse=4'b1111 in a single cycle; after release, b_held returns to 0 on all four channels 7 cycles after the release edge.
REQ-031 Reset mid-operation: rst=0 asynchronously during PRESS_DB -> outputs go 0 immediately; with the button still pressed, one pulse occurs 7 cycles after rst=1.
REQ-032 AUTO_REPEAT_EN defined, REPEAT_DELAY=10, REPEAT_PERIOD=5, b_in[3] held 30 cycles -> pulses at cycles 7, 18, 23, 28 and 33 after the press edge.
